bram_stim_seq: RTL and testbench



---
 rtl/bram_stim_pkg.sv | 51 +++++
 rtl/bram_stim_seq_if.sv | 24 ++
 rtl/bram_stim_lfsr16.sv | 26 ++
 rtl/bram_stim_seq.sv | 202 ++++++++++++++++++++
 tb/tb_bram_stim_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bram_stim_pkg.sv
// Shared types, din field layout, LFSR/MISR constants and helpers for the BRAM stimulus sequencer.
package bram_stim_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_SHIFT = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam int unsigned DIN_ADDR_LSB = 0;
   localparam int unsigned DIN_ADDR_W   = 14;
   localparam int unsigned DIN_EN_BIT   = 14;
   localparam int unsigned DIN_WE_BIT   = 15;
   localparam int unsigned DIN_DATA_LSB = 16;
   localparam int unsigned DIN_DATA_W   = 16;
   localparam int unsigned DIN_USED_W   = 32;

   // Low 32 bits of din; everything above is zero.
   typedef struct packed {
      logic [DIN_DATA_W-1:0] data;
      logic                  we;
      logic                  en;
      logic [DIN_ADDR_W-1:0] addr;
   } din_word_t;

   localparam int unsigned LFSR_W        = 16;
   localparam int unsigned SIG_W         = 32;
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [31:0] MISR_POLY     = 32'h04C11DB7;
   localparam logic [31:0] MISR_INIT     = 32'hFFFF_FFFF;
   localparam logic [15:0] ZERO_SEED_SUB = 16'h0001;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

   // One MSB-first CRC-32 shift, then fold in the captured word.
   function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] d);
      logic [31:0] s;
      s = {m[30:0], 1'b0} ^ (m[31] ? MISR_POLY : 32'h0);
      return s ^ d;
   endfunction

   function automatic logic [15:0] seed_fix(input logic [15:0] s);
      return (s == 16'h0) ? ZERO_SEED_SUB : s;
   endfunction

endpackage

// File: rtl/bram_stim_seq_if.sv
// Bus between the stimulus sequencer (master) and its surroundings: roi din/dout plus run control and signature.
interface bram_stim_seq_if #(
   parameter int unsigned DIN_N  = 160,
   parameter int unsigned DOUT_N = 160
);
   logic              start;
   logic [DIN_N-1:0]  din;
   logic [DOUT_N-1:0] dout;
   logic              busy;
   logic              done;
   logic              so;
   logic              so_valid;
   logic [15:0]       err_cnt;

   modport master (
      input  start, dout,
      output din, busy, done, so, so_valid, err_cnt
   );

   modport slave (
      output start, dout,
      input  din, busy, done, so, so_valid, err_cnt
   );
endinterface

// File: rtl/bram_stim_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load-to-seed and step controls; nxt_c is the value q takes next edge.
module bram_stim_lfsr16
   import bram_stim_pkg::*;
#(
   parameter logic [15:0] SEED = ZERO_SEED_SUB
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   output logic [15:0] q,
   output logic [15:0] nxt_c
);

   always_comb begin
      nxt_c = q;
      if (load)      nxt_c = SEED;
      else if (step) nxt_c = lfsr_next(q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= SEED;
      else     q <= nxt_c;
   end

endmodule

// File: rtl/bram_stim_seq.sv
// Self-running BRAM write/read sweep with MISR capture and serial signature out.
// Optional read-back checker enabled by defining BRAM_STIM_CHECK_EN.
module bram_stim_seq
   import bram_stim_pkg::*;
#(
   parameter int unsigned DIN_N     = 160,
   parameter int unsigned DOUT_N    = 160,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned READ_LAT  = 2,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic            clk,
   input  logic            rst,
   bram_stim_seq_if.master bus
);

   localparam int unsigned    CNT_W    = 5;
   localparam logic [15:0]    SEED_EFF = seed_fix(LFSR_SEED);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SIG_W-1:0]    misr_q, misr_d;
   logic [READ_LAT-1:0] pipe_q, pipe_d;
   logic [DIN_N-1:0]    din_q, din_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                so_q, so_d;
   logic                so_valid_q, so_valid_d;
   logic                lfsr_load, lfsr_step;
   logic                wr_c, rd_c;
   logic [15:0]         lfsr_nxt;
   logic [15:0]         lfsr_q_unused;
   logic                start_acc;
   logic                cap;
   din_word_t           dw;

   assign start_acc = (state_q == ST_IDLE) && bus.start;
   assign cap       = pipe_q[READ_LAT-1];

   bram_stim_lfsr16 #(.SEED(SEED_EFF)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .q     (lfsr_q_unused),
      .nxt_c (lfsr_nxt)
   );

   // Valid-bit pipe tracks read addresses in flight through roi.
   generate
      if (READ_LAT == 1) begin : g_pipe1
         assign pipe_d = state_q == ST_READ;
      end else begin : g_pipen
         assign pipe_d = {pipe_q[READ_LAT-2:0], state_q == ST_READ};
      end
      if (DOUT_N > SIG_W) begin : g_dout_hi
         logic dout_hi_unused;
         assign dout_hi_unused = ^bus.dout[DOUT_N-1:SIG_W];
      end
   endgenerate

   // Next-state and next-output values; outputs are registered from these.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      misr_d    = misr_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      wr_c      = 1'b0;
      rd_c      = 1'b0;
      dw        = '0;
      din_d     = '0;

      if (cap) misr_d = misr_step(misr_q, bus.dout[SIG_W-1:0]);

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d   = ST_WRITE;
               addr_d    = '0;
               lfsr_load = 1'b1;
               misr_d    = MISR_INIT;
               wr_c      = 1'b1;
            end
         end
         ST_WRITE: begin
            if (&addr_q) begin
               state_d   = ST_READ;
               addr_d    = '0;
               lfsr_load = 1'b1;
               rd_c      = 1'b1;
            end else begin
               addr_d    = addr_q + ADDR_W'(1);
               lfsr_step = 1'b1;
               wr_c      = 1'b1;
            end
         end
         ST_READ: begin
            if (&addr_q) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
               rd_c   = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == CNT_W'(READ_LAT - 1)) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_SHIFT: begin
            misr_d = {misr_q[SIG_W-2:0], 1'b0};
            if (cnt_q == CNT_W'(SIG_W - 1)) state_d = ST_DONE;
            else                            cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (wr_c || rd_c) begin
         dw.addr = DIN_ADDR_W'(addr_d);
         dw.en   = 1'b1;
         if (wr_c) begin
            dw.we   = 1'b1;
            dw.data = lfsr_nxt;
         end
         din_d = DIN_N'(dw);
      end

      busy_d     = state_d != ST_IDLE;
      done_d     = state_d == ST_DONE;
      so_valid_d = state_d == ST_SHIFT;
      so_d       = so_valid_d & misr_d[SIG_W-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         misr_q     <= MISR_INIT;
         pipe_q     <= '0;
         din_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         so_q       <= 1'b0;
         so_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         misr_q     <= misr_d;
         pipe_q     <= pipe_d;
         din_q      <= din_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         so_q       <= so_d;
         so_valid_q <= so_valid_d;
      end
   end

   assign bus.din      = din_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.so       = so_q;
   assign bus.so_valid = so_valid_q;

`ifdef BRAM_STIM_CHECK_EN
   // Expected-data LFSR advances once per capture, so it trails the write stream by the read latency.
   logic [15:0] exp_q;
   logic [15:0] exp_nxt_unused;
   logic [15:0] err_q;

   bram_stim_lfsr16 #(.SEED(SEED_EFF)) u_exp_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (start_acc),
      .step  (cap),
      .q     (exp_q),
      .nxt_c (exp_nxt_unused)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                    err_q <= '0;
      else if (start_acc)                                         err_q <= '0;
      else if (cap && bus.dout[15:0] != exp_q && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
   end

   assign bus.err_cnt = err_q;
`else
   logic start_acc_unused;
   assign start_acc_unused = start_acc;
   assign bus.err_cnt      = '0;
`endif

endmodule

// File: tb/tb_bram_stim_seq.sv
// Directed bench for bram_stim_seq: behavioural 2-cycle RAM, scoreboard for din, model MISR for the signature.
module tb_bram_stim_seq;

   localparam int          N        = 4;
   localparam int          RUN_LEN  = 2 * N + 2 + 32 + 1;
   localparam logic [15:0] SEED     = 16'hACE1;
`ifdef BRAM_STIM_CHECK_EN
   localparam logic [15:0] INJ_ERR  = 16'd1;
`else
   localparam logic [15:0] INJ_ERR  = 16'd0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bram_stim_seq_if #(.DIN_N(160), .DOUT_N(160)) bus ();
   bram_stim_seq_if #(.DIN_N(160), .DOUT_N(160)) bus0 ();

   bram_stim_seq #(.DIN_N(160), .DOUT_N(160), .ADDR_W(2), .READ_LAT(2), .LFSR_SEED(SEED)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   bram_stim_seq #(.DIN_N(160), .DOUT_N(160), .ADDR_W(1), .READ_LAT(1), .LFSR_SEED(16'h0000)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   assign bus0.dout = '0;

   int          checks = 0;
   int          passed = 0;
   bit          inject = 1'b0;
   logic [31:0] exp_din[$];

   // Behavioural RAM: address in cycle c, data on dout during cycle c+2.
   logic [15:0] mem [0:3];
   logic        p1_v;
   logic [15:0] p1_d;
   int          rcnt;

   always @(posedge clk) begin
      if (rst) p1_v <= 1'b0;
      else     p1_v <= bus.din[14] && !bus.din[15];
      if (bus.start) rcnt <= 0;
      else if (p1_v) rcnt <= rcnt + 1;
      if (bus.din[14] && bus.din[15]) mem[bus.din[1:0]] <= bus.din[31:16];
      p1_d <= mem[bus.din[1:0]];
      if (p1_v)
         bus.dout <= {{128{1'b1}}, p1_d ^ 16'h5A5A, p1_d ^ ((inject && rcnt == 2) ? 16'h0008 : 16'h0000)};
   end

   function automatic logic [15:0] m_lfsr(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic logic [31:0] m_crc(input logic [31:0] m, input logic [31:0] d);
      logic [31:0] r;
      r = m << 1;
      if (m[31]) r = r ^ 32'h04C11DB7;
      return r ^ d;
   endfunction

   function automatic logic [31:0] model_sig(input bit inj);
      logic [15:0] s;
      logic [31:0] m;
      logic [15:0] lo;
      s = SEED;
      m = 32'hFFFF_FFFF;
      for (int k = 0; k < N; k++) begin
         lo = s ^ ((inj && k == 2) ? 16'h0008 : 16'h0000);
         m  = m_crc(m, {s ^ 16'h5A5A, lo});
         s  = m_lfsr(s);
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push_din();
      logic [15:0] s;
      s = SEED;
      for (int k = 0; k < N; k++) begin
         exp_din.push_back({s, 2'b11, 14'(k)});
         s = m_lfsr(s);
      end
      for (int k = 0; k < N; k++) exp_din.push_back({16'h0000, 2'b01, 14'(k)});
   endtask

   task automatic do_run(input int abort_at, input int restart_at,
                         input logic [31:0] exp_sig, input logic [15:0] exp_err,
                         output logic [31:0] sig);
      int cyc, done_cyc, first_cyc, nbits, busy_n;
      cyc = 0; done_cyc = 0; first_cyc = 0; nbits = 0; busy_n = 0; sig = '0;
      push_din();
      @(negedge clk) bus.start = 1'b1;
      while (done_cyc == 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         bus.start = (cyc == restart_at);
         if (cyc == abort_at) begin
            rst = 1'b1;
            #1;
            chk("abort_din", bus.din[63:0], 64'h0);
            chk("abort_busy", 64'(bus.busy), 64'h0);
            exp_din.delete();
            return;
         end
         if (bus.busy) busy_n++;
         if (bus.din[14]) begin
            if (first_cyc == 0) first_cyc = cyc;
            if (exp_din.size() == 0) chk("din_extra", 64'h1, 64'h0);
            else chk("din", bus.din[63:0], {32'h0, exp_din.pop_front()});
         end
         if (bus.so_valid) begin
            sig = {sig[30:0], bus.so};
            nbits++;
         end
         if (bus.done) done_cyc = cyc;
      end
      chk("first_write_cyc", 64'(first_cyc), 64'd1);
      chk("done_cyc", 64'(done_cyc), 64'(RUN_LEN));
      chk("busy_span", 64'(busy_n), 64'(RUN_LEN));
      chk("din_left", 64'(exp_din.size()), 64'h0);
      chk("sig_bits", 64'(nbits), 64'd32);
      chk("signature", 64'(sig), 64'(exp_sig));
      chk("err_cnt", 64'(bus.err_cnt), 64'(exp_err));
      @(negedge clk);
      chk("busy_fall", 64'(bus.busy), 64'h0);
      chk("done_pulse", 64'(bus.done), 64'h0);
   endtask

   initial begin
      logic [31:0] golden, sig;
      int          nz;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus0.start = 1'b0;
      golden     = model_sig(1'b0);

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_din", bus.din[63:0], 64'h0);
      chk("rst_busy", 64'(bus.busy), 64'h0);
      chk("rst_done", 64'(bus.done), 64'h0);
      chk("rst_so", 64'(bus.so), 64'h0);
      chk("rst_so_valid", 64'(bus.so_valid), 64'h0);
      chk("rst_err_cnt", 64'(bus.err_cnt), 64'h0);
      rst = 1'b0;
      nz  = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.din != '0 || bus.busy) nz++;
      end
      chk("idle_100", 64'(nz), 64'h0);

      // Clean run
      do_run(0, 0, golden, 16'd0, sig);

      // Start pulse during READ is ignored
      do_run(0, 6, golden, 16'd0, sig);

      // Reset on the 2nd WRITE cycle, then a fresh run
      do_run(2, 0, golden, 16'd0, sig);
      @(negedge clk) rst = 1'b0;
      repeat (3) @(negedge clk);
      do_run(0, 0, golden, 16'd0, sig);

      // Corrupt the 3rd capture
      inject = 1'b1;
      do_run(0, 0, model_sig(1'b1), INJ_ERR, sig);
      chk("sig_differs", 64'(sig != golden), 64'h1);
      inject = 1'b0;
      do_run(0, 0, golden, 16'd0, sig);

      // Zero seed replaced by 0x0001
      @(negedge clk) bus0.start = 1'b1;
      @(negedge clk) bus0.start = 1'b0;
      chk("zs_first", bus0.din[63:0], {32'h0, 16'h0001, 2'b11, 14'h0});
      @(negedge clk);
      chk("zs_second", bus0.din[63:0], {32'h0, 16'h0002, 2'b11, 14'h1});
      repeat (40) @(negedge clk);
      chk("zs_idle", 64'(bus0.busy), 64'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
